// File: rtl/iob2axi_burst_pkg.sv
// Shared AXI4 encodings and bridge state type for the native-to-AXI burst bridge.
package iob2axi_burst_pkg;

    localparam int AXI_LEN_W = 8;
    localparam int AXI_PAGE_BYTES = 4096;

    localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;
    localparam logic [1:0] AXI_LOCK_NORMAL   = 2'b00;
    localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0010;
    localparam logic [2:0] AXI_PROT_DEFAULT  = 3'b000;
    localparam logic [3:0] AXI_QOS_DEFAULT   = 4'b0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_W_ADDR,
        ST_W_DATA,
        ST_W_RESP,
        ST_R_ADDR,
        ST_R_DATA
    } state_t;

    // AXI size encoding for a bus of data_w bits
    function automatic logic [2:0] axi_size(input int data_w);
        return 3'($clog2(data_w / 8));
    endfunction

endpackage

// File: rtl/iob2axi_burst_calc.sv
// Registered next-burst computation: current burst address, beat count and
// whether this burst finishes the transfer. Updated on load and at each burst end.
module iob2axi_burst_calc
    import iob2axi_burst_pkg::*;
#(
    parameter int ADDR_W  = 24,
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 16,
    parameter int BURST_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               advance,
    input  logic [ADDR_W-1:0]  load_addr,
    input  logic [LEN_W-1:0]   load_len,
    output logic [ADDR_W-1:0]  burst_addr,
    output logic [BURST_W:0]   burst_beats,
    output logic               burst_last
);

    localparam int SIZE      = $clog2(DATA_W / 8);
    localparam int MAX_BEATS = 1 << BURST_W;

    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [LEN_W-1:0]  rem_reg, rem_next;
    logic [BURST_W:0]  beats_reg, beats_next;
    logic              last_reg, last_next;

    // Beats of the burst starting at a: bounded by what is left, the max
    // burst length and the words remaining before the next 4 KB page.
    function automatic logic [BURST_W:0] calc_beats(input logic [ADDR_W-1:0] a,
                                                    input logic [LEN_W-1:0]  rem);
        logic [31:0] page_words;
        logic [31:0] limit;
        page_words = (32'(AXI_PAGE_BYTES) - 32'(a[11:0])) >> SIZE;
        limit = 32'(MAX_BEATS);
        if (page_words < limit) limit = page_words;
        if (32'(rem) < limit)   limit = 32'(rem);
        return limit[BURST_W:0];
    endfunction

    // Select the state the next burst is computed from
    always_comb begin
        addr_next = addr_reg;
        rem_next  = rem_reg;
        if (load) begin
            addr_next = load_addr & ~ADDR_W'(DATA_W / 8 - 1);
            rem_next  = load_len;
        end else if (advance) begin
            addr_next = addr_reg + (ADDR_W'(beats_reg) << SIZE);
            rem_next  = rem_reg - LEN_W'(beats_reg);
        end
        beats_next = calc_beats(addr_next, rem_next);
        last_next  = (32'(rem_next) == 32'(beats_next));
    end

    // Register the burst parameters so the AXI address fields come straight from flops
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_reg  <= '0;
            rem_reg   <= '0;
            beats_reg <= '0;
            last_reg  <= 1'b0;
        end else if (load || advance) begin
            addr_reg  <= addr_next;
            rem_reg   <= rem_next;
            beats_reg <= beats_next;
            last_reg  <= last_next;
        end
    end

    assign burst_addr  = addr_reg;
    assign burst_beats = beats_reg;
    assign burst_last  = last_reg;

endmodule

// File: rtl/iob2axi_burst.sv
// Native-stream to AXI4 burst bridge: one outstanding burst at a time, in
// either direction, with bursts split at the max length and at 4 KB pages.
module iob2axi_burst
    import iob2axi_burst_pkg::*;
#(
    parameter int ADDR_W   = 24,
    parameter int DATA_W   = 32,
    parameter int LEN_W    = 16,
    parameter int BURST_W  = 4,
    parameter int AXI_ID_W = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    input  logic                  direction,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [LEN_W-1:0]      length,
    output logic                  ready,
    output logic                  error,
    input  logic                  s_valid,
    input  logic [DATA_W-1:0]     s_wdata,
    input  logic [DATA_W/8-1:0]   s_wstrb,
    output logic [DATA_W-1:0]     s_rdata,
    output logic                  s_ready,
    output logic [AXI_ID_W-1:0]   m_axi_awid,
    output logic [ADDR_W-1:0]     m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic [1:0]            m_axi_awlock,
    output logic [3:0]            m_axi_awcache,
    output logic [2:0]            m_axi_awprot,
    output logic [3:0]            m_axi_awqos,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_W-1:0]     m_axi_wdata,
    output logic [DATA_W/8-1:0]   m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [AXI_ID_W-1:0]   m_axi_bid,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [AXI_ID_W-1:0]   m_axi_arid,
    output logic [ADDR_W-1:0]     m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic [1:0]            m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic [3:0]            m_axi_arqos,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [AXI_ID_W-1:0]   m_axi_rid,
    input  logic [DATA_W-1:0]     m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    localparam logic [BURST_W:0] ONE_BEAT = 1;

    state_t            state_reg;
    logic              error_reg;
    logic              awvalid_reg;
    logic              arvalid_reg;
    logic              bready_reg;
    logic [BURST_W:0]  beat_cnt_reg;

    logic [ADDR_W-1:0] burst_addr;
    logic [BURST_W:0]  burst_beats;
    logic              burst_last;
    logic              start;
    logic              beat_final;
    logic              w_fire;
    logic              r_fire;
    logic              advance;
    logic [7:0]        axi_len;

    // IDs are always zero, so returned IDs carry no information
    logic unused_ids;
    assign unused_ids = ^{m_axi_bid, m_axi_rid};

    assign start      = (state_reg == ST_IDLE) && run && (length != '0);
    assign beat_final = (beat_cnt_reg == burst_beats - ONE_BEAT);
    assign w_fire     = (state_reg == ST_W_DATA) && s_valid && m_axi_wready;
    assign r_fire     = (state_reg == ST_R_DATA) && s_valid && m_axi_rvalid;
    assign advance    = ((state_reg == ST_W_RESP) && m_axi_bvalid) || (r_fire && beat_final);
    assign axi_len    = AXI_LEN_W'(burst_beats - ONE_BEAT);

    iob2axi_burst_calc #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .LEN_W   (LEN_W),
        .BURST_W (BURST_W)
    ) u_calc (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (start),
        .advance     (advance),
        .load_addr   (addr),
        .load_len    (length),
        .burst_addr  (burst_addr),
        .burst_beats (burst_beats),
        .burst_last  (burst_last)
    );

    // Control FSM for both directions plus the per-burst beat counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            error_reg    <= 1'b0;
            awvalid_reg  <= 1'b0;
            arvalid_reg  <= 1'b0;
            bready_reg   <= 1'b0;
            beat_cnt_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        error_reg    <= 1'b0;
                        beat_cnt_reg <= '0;
                        if (direction) begin
                            state_reg   <= ST_W_ADDR;
                            awvalid_reg <= 1'b1;
                        end else begin
                            state_reg   <= ST_R_ADDR;
                            arvalid_reg <= 1'b1;
                        end
                    end
                end
                ST_W_ADDR: begin
                    if (m_axi_awready) begin
                        awvalid_reg  <= 1'b0;
                        beat_cnt_reg <= '0;
                        state_reg    <= ST_W_DATA;
                    end
                end
                ST_W_DATA: begin
                    if (w_fire) begin
                        if (beat_final) begin
                            state_reg  <= ST_W_RESP;
                            bready_reg <= 1'b1;
                        end else begin
                            beat_cnt_reg <= beat_cnt_reg + ONE_BEAT;
                        end
                    end
                end
                ST_W_RESP: begin
                    if (m_axi_bvalid) begin
                        bready_reg <= 1'b0;
                        if (m_axi_bresp != AXI_RESP_OKAY) error_reg <= 1'b1;
                        if (burst_last) begin
                            state_reg <= ST_IDLE;
                        end else begin
                            state_reg   <= ST_W_ADDR;
                            awvalid_reg <= 1'b1;
                        end
                    end
                end
                ST_R_ADDR: begin
                    if (m_axi_arready) begin
                        arvalid_reg  <= 1'b0;
                        beat_cnt_reg <= '0;
                        state_reg    <= ST_R_DATA;
                    end
                end
                ST_R_DATA: begin
                    if (r_fire) begin
                        // Burst end is counted; rlast only serves as a consistency check
                        if ((m_axi_rresp != AXI_RESP_OKAY) || (m_axi_rlast != beat_final))
                            error_reg <= 1'b1;
                        if (beat_final) begin
                            if (burst_last) begin
                                state_reg <= ST_IDLE;
                            end else begin
                                state_reg   <= ST_R_ADDR;
                                arvalid_reg <= 1'b1;
                            end
                        end else begin
                            beat_cnt_reg <= beat_cnt_reg + ONE_BEAT;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign ready = (state_reg == ST_IDLE);
    assign error = error_reg;

    // Native side: handshakes pass straight through during the data phases only
    assign s_ready = ((state_reg == ST_W_DATA) && m_axi_wready) ||
                     ((state_reg == ST_R_DATA) && m_axi_rvalid);
    assign s_rdata = m_axi_rdata;

    assign m_axi_awid    = '0;
    assign m_axi_awaddr  = burst_addr;
    assign m_axi_awlen   = axi_len;
    assign m_axi_awsize  = axi_size(DATA_W);
    assign m_axi_awburst = AXI_BURST_INCR;
    assign m_axi_awlock  = AXI_LOCK_NORMAL;
    assign m_axi_awcache = AXI_CACHE_DEFAULT;
    assign m_axi_awprot  = AXI_PROT_DEFAULT;
    assign m_axi_awqos   = AXI_QOS_DEFAULT;
    assign m_axi_awvalid = awvalid_reg;

    assign m_axi_wdata  = s_wdata;
    assign m_axi_wstrb  = s_wstrb;
    assign m_axi_wvalid = (state_reg == ST_W_DATA) && s_valid;
    assign m_axi_wlast  = (state_reg == ST_W_DATA) && beat_final;
    assign m_axi_bready = bready_reg;

    assign m_axi_arid    = '0;
    assign m_axi_araddr  = burst_addr;
    assign m_axi_arlen   = axi_len;
    assign m_axi_arsize  = axi_size(DATA_W);
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_arlock  = AXI_LOCK_NORMAL;
    assign m_axi_arcache = AXI_CACHE_DEFAULT;
    assign m_axi_arprot  = AXI_PROT_DEFAULT;
    assign m_axi_arqos   = AXI_QOS_DEFAULT;
    assign m_axi_arvalid = arvalid_reg;
    assign m_axi_rready  = (state_reg == ST_R_DATA) && s_valid;

endmodule

// File: tb/tb_iob2axi_burst.sv
// Directed bench for iob2axi_burst with a behavioural single-burst AXI4 slave memory.
module tb_iob2axi_burst;

    localparam int ADDR_W = 24, DATA_W = 32, LEN_W = 16, BURST_W = 4, AXI_ID_W = 1;
    localparam int STRB_W = DATA_W / 8;
    localparam int BUDGET = 20000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic run = 1'b0, direction = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [LEN_W-1:0] length = '0;
    logic ready, error;
    logic s_valid = 1'b0;
    logic [DATA_W-1:0] s_wdata = '0;
    logic [STRB_W-1:0] s_wstrb = '1;
    logic [DATA_W-1:0] s_rdata;
    logic s_ready;

    logic [AXI_ID_W-1:0] awid, arid;
    logic [ADDR_W-1:0] awaddr, araddr;
    logic [7:0] awlen, arlen;
    logic [2:0] awsize, arsize, awprot, arprot;
    logic [1:0] awburst, arburst, awlock, arlock;
    logic [3:0] awcache, arcache, awqos, arqos;
    logic awvalid, arvalid;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic wlast, wvalid, bready, rready;
    logic awready, arready;
    logic wready = 1'b0;
    logic [1:0] bresp = 2'b00;
    logic bvalid = 1'b0;
    logic [DATA_W-1:0] rdata = '0;
    logic rlast = 1'b0, rvalid = 1'b0;
    logic [AXI_ID_W-1:0] bid, rid;
    logic [1:0] rresp;

    assign awready = 1'b1;
    assign arready = 1'b1;
    assign bid = '0;
    assign rid = '0;
    assign rresp = 2'b00;

    iob2axi_burst #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .BURST_W(BURST_W), .AXI_ID_W(AXI_ID_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .direction(direction), .addr(addr), .length(length),
        .ready(ready), .error(error), .s_valid(s_valid), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_rdata(s_rdata), .s_ready(s_ready),
        .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
        .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache),
        .m_axi_awprot(awprot), .m_axi_awqos(awqos), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast), .m_axi_wvalid(wvalid),
        .m_axi_wready(wready), .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid),
        .m_axi_bready(bready),
        .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
        .m_axi_arburst(arburst), .m_axi_arlock(arlock), .m_axi_arcache(arcache),
        .m_axi_arprot(arprot), .m_axi_arqos(arqos), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Slave memory (64 KB window) and transaction logs
    logic [DATA_W-1:0] mem [0:16383];
    logic [ADDR_W-1:0] aw_addr_q[$];
    logic [7:0]        aw_len_q[$];
    logic [ADDR_W-1:0] ar_addr_q[$];
    logic [7:0]        ar_len_q[$];
    int w_beats = 0;
    int b_idx = 0;
    int b_count = 0;
    int err_burst = -1;
    bit stall_en = 1'b0;

    logic [ADDR_W-1:0] w_addr = '0, r_addr = '0;
    logic [7:0] w_cnt = '0, w_len = '0, r_left = '0;

    // Behavioural AXI slave: accepts one burst at a time, writes/reads mem
    always @(posedge clk) begin
        if (!rst_n) begin
            wready <= 1'b0;
            bvalid <= 1'b0;
            rvalid <= 1'b0;
            rlast  <= 1'b0;
        end else begin
            wready <= stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (awvalid && awready) begin
                aw_addr_q.push_back(awaddr);
                aw_len_q.push_back(awlen);
                w_addr <= awaddr;
                w_cnt  <= '0;
                w_len  <= awlen;
            end
            if (bvalid && bready) begin
                bvalid  <= 1'b0;
                b_count <= b_count + 1;
            end
            if (wvalid && wready) begin
                check("wlast", wlast, w_cnt == w_len);
                for (int b = 0; b < STRB_W; b++)
                    if (wstrb[b]) mem[w_addr[15:2]][8*b +: 8] <= wdata[8*b +: 8];
                w_addr  <= w_addr + 4;
                w_cnt   <= w_cnt + 1;
                w_beats <= w_beats + 1;
                if (w_cnt == w_len) begin
                    bvalid <= 1'b1;
                    bresp  <= (b_idx == err_burst) ? 2'b10 : 2'b00;
                    b_idx  <= b_idx + 1;
                end
            end
            if (arvalid && arready) begin
                ar_addr_q.push_back(araddr);
                ar_len_q.push_back(arlen);
                r_addr <= araddr;
                r_left <= arlen;
                rvalid <= 1'b1;
                rdata  <= mem[araddr[15:2]];
                rlast  <= (arlen == 0);
            end else if (rvalid && rready) begin
                if (r_left == 0) begin
                    rvalid <= 1'b0;
                    rlast  <= 1'b0;
                end else begin
                    r_addr <= r_addr + 4;
                    rdata  <= mem[r_addr[15:2] + 14'd1];
                    r_left <= r_left - 1;
                    rlast  <= (r_left == 1);
                end
            end
        end
    end

    logic [DATA_W-1:0] rd_buf [0:2047];

    // Issue one run and drive the native side until done, stop_at beats, or budget
    task automatic xfer(input bit dir, input logic [ADDR_W-1:0] a, input int len,
                        input int base, input bit toggle, input int stop_at, output int done);
        int n;
        int cyc;
        n = 0;
        cyc = 0;
        @(negedge clk);
        run = 1'b1;
        direction = dir;
        addr = a;
        length = LEN_W'(len);
        @(negedge clk);
        run = 1'b0;
        check(len == 0 ? "ready_len0" : "ready_fall", ready, len == 0);
        forever begin
            if (stop_at >= 0 && n == stop_at) break;
            if (n == len && ready) break;
            if (cyc == BUDGET) begin
                check("xfer_timeout", n, len);
                break;
            end
            s_valid = (n < len) && (!toggle || (cyc % 2 == 0));
            s_wdata = DATA_W'(base + n);
            #1;
            if (s_valid && s_ready) begin
                if (!dir) rd_buf[n] = s_rdata;
                n++;
            end
            cyc++;
            @(negedge clk);
        end
        s_valid = 1'b0;
        done = n;
        $display("TXN dir=%0d addr=0x%0h len=%0d beats=%0d error=%0b ready=%0b",
                 dir, a, len, n, error, ready);
    endtask

    initial begin
        int n, aw0, ar0, wb0, bc0, mism;

        // Reset state and constant AXI fields
        repeat (3) @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_error", error, 0);
        check("rst_awvalid", awvalid, 0);
        check("rst_arvalid", arvalid, 0);
        check("rst_wvalid", wvalid, 0);
        check("rst_bready", bready, 0);
        check("rst_rready", rready, 0);
        check("rst_s_ready", s_ready, 0);
        check("awsize", awsize, 3'd2);
        check("awburst", awburst, 2'b01);
        check("awcache", awcache, 4'b0010);
        check("arsize", arsize, 3'd2);
        check("arburst", arburst, 2'b01);
        check("fixed_zero", {awid, awlock, awprot, awqos, arid, arlock, arprot, arqos}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1024-word write across a 4 KB page boundary
        aw0 = aw_addr_q.size(); wb0 = w_beats;
        xfer(1'b1, 24'h7FD8, 1024, 32, 1'b0, -1, n);
        check("wr_beats", n, 1024);
        check("wr_wbeats", w_beats - wb0, 1024);
        check("wr_bursts", aw_addr_q.size() - aw0, 65);
        check("aw0_addr", aw_addr_q[aw0], 24'h7FD8);
        check("aw0_len", aw_len_q[aw0], 9);
        check("aw1_addr", aw_addr_q[aw0 + 1], 24'h8000);
        check("aw1_len", aw_len_q[aw0 + 1], 15);
        check("awlast_addr", aw_addr_q[aw0 + 64], 24'h8FC0);
        check("awlast_len", aw_len_q[aw0 + 64], 5);
        mism = 0;
        for (int k = 1; k < 64; k++)
            if (aw_len_q[aw0 + k] != 8'd15 || aw_addr_q[aw0 + k] != 24'h8000 + 24'(64 * (k - 1))) mism++;
        check("aw_mid", mism, 0);
        mism = 0;
        for (int i = 0; i < 1024; i++) if (mem[14'h1FF6 + 14'(i)] !== 32'(i + 32)) mism++;
        check("wr_mem", mism, 0);
        check("wr_error", error, 0);
        check("wr_ready", ready, 1);

        // Read the same region back
        ar0 = ar_addr_q.size();
        xfer(1'b0, 24'h7FD8, 1024, 0, 1'b0, -1, n);
        check("rd_beats", n, 1024);
        mism = 0;
        for (int i = 0; i < 1024; i++) if (rd_buf[i] !== 32'(i + 32)) mism++;
        check("rd_data", mism, 0);
        check("rd_bursts", ar_addr_q.size() - ar0, 65);
        mism = 0;
        for (int k = 0; k < 65; k++)
            if (ar_addr_q[ar0 + k] !== aw_addr_q[aw0 + k] || ar_len_q[ar0 + k] !== aw_len_q[aw0 + k]) mism++;
        check("ar_seq", mism, 0);
        check("rd_error", error, 0);

        // Single word, unaligned byte address is aligned down
        aw0 = aw_addr_q.size(); bc0 = b_count;
        xfer(1'b1, 24'h000102, 1, 32'hA5A50000, 1'b0, -1, n);
        check("one_bursts", aw_addr_q.size() - aw0, 1);
        check("one_addr", aw_addr_q[aw0], 24'h000100);
        check("one_len", aw_len_q[aw0], 0);
        check("one_b", b_count - bc0, 1);
        check("one_mem", mem[14'h40], 32'hA5A50000);
        check("one_ready", ready, 1);

        // SLVERR on the third burst of a 64-word write
        aw0 = aw_addr_q.size(); bc0 = b_count;
        err_burst = b_idx + 2;
        xfer(1'b1, 24'h0, 64, 32'h1000, 1'b0, -1, n);
        check("err_bursts", aw_addr_q.size() - aw0, 4);
        check("err_b", b_count - bc0, 4);
        check("err_flag", error, 1);
        err_burst = -1;

        // length=0 is a no-op: no burst, error preserved
        aw0 = aw_addr_q.size();
        xfer(1'b1, 24'h40, 0, 0, 1'b0, -1, n);
        repeat (2) @(negedge clk);
        check("len0_bursts", aw_addr_q.size() - aw0, 0);
        check("len0_error", error, 1);
        check("len0_ready", ready, 1);

        // Next accepted run clears error
        xfer(1'b1, 24'h300, 1, 32'h77, 1'b0, -1, n);
        check("clr_error", error, 0);
        check("clr_mem", mem[14'hC0], 32'h77);

        // Gapped s_valid with random wready stalls, then gapped read back
        aw0 = aw_addr_q.size(); wb0 = w_beats;
        stall_en = 1'b1;
        xfer(1'b1, 24'h200, 40, 32'h5000, 1'b1, -1, n);
        stall_en = 1'b0;
        check("stall_wbeats", w_beats - wb0, 40);
        check("stall_bursts", aw_addr_q.size() - aw0, 3);
        check("stall_lastlen", aw_len_q[aw0 + 2], 7);
        mism = 0;
        for (int i = 0; i < 40; i++) if (mem[14'h80 + 14'(i)] !== 32'(32'h5000 + i)) mism++;
        check("stall_mem", mism, 0);
        xfer(1'b0, 24'h200, 40, 0, 1'b1, -1, n);
        mism = 0;
        for (int i = 0; i < 40; i++) if (rd_buf[i] !== 32'(32'h5000 + i)) mism++;
        check("gap_rd_data", mism, 0);
        check("gap_rd_error", error, 0);

        // Reset in the middle of the second burst's data phase, with error set
        err_burst = b_idx;
        xfer(1'b1, 24'h1000, 32, 32'h7000, 1'b0, 20, n);
        check("mid_beats", n, 20);
        check("mid_error_pre", error, 1);
        err_burst = -1;
        s_valid = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_ready", ready, 1);
        check("mid_error", error, 0);
        check("mid_awvalid", awvalid, 0);
        check("mid_wvalid", wvalid, 0);
        check("mid_arvalid", arvalid, 0);
        check("mid_bready", bready, 0);
        check("mid_s_ready", s_ready, 0);
        s_valid = 1'b0;

        // Fresh 16-word write after the reset
        aw0 = aw_addr_q.size();
        xfer(1'b1, 24'h3000, 16, 32'h9000, 1'b0, -1, n);
        check("post_bursts", aw_addr_q.size() - aw0, 1);
        check("post_addr", aw_addr_q[aw0], 24'h3000);
        check("post_len", aw_len_q[aw0], 15);
        mism = 0;
        for (int i = 0; i < 16; i++) if (mem[14'hC00 + 14'(i)] !== 32'(32'h9000 + i)) mism++;
        check("post_mem", mism, 0);
        check("post_error", error, 0);
        check("post_ready", ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/iob2axi_burst.md
Name: iob2axi_burst

Overview:
Next-generation native-to-AXI4 burst bridge. On a `run` command it moves a programmable number of words, in either direction, between the native slave stream and an AXI4 full master port. Bursts are split automatically at a parametrised maximum length and at 4 KB boundaries, and AXI response errors are detected. It sits between a native-interface producer/consumer (DMA engine, accelerator) and the DDR/interconnect AXI port.

Parameters:
ADDR_W, 24, native and AXI byte address width
DATA_W, 32, data width (power of 2, at least 8); AXI data width is equal
LEN_W, 16, width of the transfer length in words
BURST_W, 4, log2 of max beats per burst (at most 8; max burst 2**BURST_W)
AXI_ID_W, 1, AXI ID width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
run  in  1  start pulse; accepted only when ready=1
direction  in  1  1=write (native to AXI), 0=read (AXI to native)
addr  in  ADDR_W  start byte address; low log2(DATA_W/8) bits ignored
length  in  LEN_W  transfer length in words
ready  out  1  idle, can accept run
error  out  1  sticky: any BRESP/RRESP not equal 0 during the current transfer
s_valid  in  1  native beat request
s_wdata  in  DATA_W  write data
s_wstrb  in  DATA_W/8  write strobes (ignored on read)
s_rdata  out  DATA_W  read data, valid when s_ready=1 on a read
s_ready  out  1  beat accepted/delivered this cycle
m_axi_aw{id,addr,len,size,burst,lock,cache,prot,qos,valid}  out  AXI_ID_W,ADDR_W,8,3,2,2,4,3,4,1  write address
m_axi_awready  in  1
m_axi_w{data,strb,last,valid}  out  DATA_W,DATA_W/8,1,1  write data
m_axi_wready  in  1
m_axi_b{id,resp,valid}  in  AXI_ID_W,2,1 ; m_axi_bready  out  1
m_axi_ar{id,addr,len,size,burst,lock,cache,prot,qos,valid}  out  as AW  read address
m_axi_arready  in  1
m_axi_r{id,data,resp,last,valid}  in  AXI_ID_W,DATA_W,2,1,1 ; m_axi_rready  out  1

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; ready=1, error=0; all m_axi_*valid=0, bready=0, rready=0, s_ready=0. Applies mid-burst; the AXI slave must be reset with the bridge.
- Constant fields: id=0, size=log2(DATA_W/8), burst=INCR (01), lock=0, cache=0010, prot=000, qos=0.
- IDLE: run=1 latches addr (aligned), length, direction; clears error; ready falls next cycle. If length=0, run is a no-op: ready stays 1 and error is unchanged. run while ready=0 is ignored.
- Burst size: beats = min(remaining, 2**BURST_W, (4096 - addr[11:0]) / (DATA_W/8)); *len = beats - 1.
- Write FSM: IDLE -> W_ADDR -> W_DATA -> W_RESP, then back to W_ADDR if remaining > 0, else IDLE.
  - W_ADDR: awvalid=1 until awready; addr/len are held stable while valid.
  - W_DATA: wvalid=s_valid; wdata/wstrb pass through combinationally; s_ready=wready; wlast=1 on the final beat of the burst. Beat counter advances on wvalid&wready.
  - W_RESP: bready=1; on bvalid, bresp not equal 0 sets error; address advances by beats*DATA_W/8 and remaining decrements by beats.
- Read FSM: IDLE -> R_ADDR -> R_DATA, then back to R_ADDR if remaining > 0, else IDLE.
  - R_ADDR: arvalid until arready.
  - R_DATA: rready=s_valid; s_ready=rvalid; s_rdata=rdata; rresp not equal 0 on any beat sets error. The burst ends on the counted last beat. rlast is not used for control; an rlast mismatch sets error.
- Outside W_DATA/R_DATA, s_ready=0; s_valid there is held off and no data is lost.
- Only one outstanding burst at a time; address and data phases never overlap.
- ready rises the cycle after the final B handshake (write) or final R beat (read).
- error holds until the next accepted run; the transfer always runs to completion after an error.

Decomposition:
- Shared package/header (axi.vh): AXI burst/resp/size encodings, cache/prot defaults, AXI_LEN_W=8.
- Sub-module iob2axi_burst_calc: registered next-burst computation (beats, next address, remaining, last flag), updated at each burst end. The top level holds both FSMs and the beat counter.

Test Plan:
- Defaults (BURST_W=4). Write 1024 words from addr=0x7FD8, data=i+32 -> first burst awaddr=0x7FD8 awlen=9; next awaddr=0x8000 awlen=15; 65 bursts total, last awlen=5; error=0; ready=1 at end.
- Read back 1024 words from 0x7FD8 -> s_rdata==i+32 for every i; AR sequence identical to the AW sequence above.
- length=1, addr=0x100, write -> one burst, awlen=0, wlast on the first beat, single B; ready returns.
- Slave returns BRESP=2 on burst 3 of a 64-word write at addr 0 -> error=1 after that B; all 4 bursts complete. Next run with length=1 -> error=0.
- s_valid toggled every other cycle and wready randomly stalled during write -> exactly `length` W beats; memory matches; no duplicated or dropped beats.
- rst_n=0 for 1 cycle mid W_DATA -> next cycle all valids=0, ready=1, error=0; a fresh 16-word write then succeeds.
